// File: rtl/node_ctrl_pkg.sv
//------------------------------------------------------------------------------
// node_ctrl_pkg : shared types and default sizes for the node sequencer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package node_ctrl_pkg;

  localparam int CNT_W      = 7;
  localparam int DATA_W     = 16;
  localparam int NUM_INPUTS = 64;

  typedef logic [DATA_W-1:0] node_data_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCUM  = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/node_ctrl_if.sv
//------------------------------------------------------------------------------
// node_ctrl_if : request/result handshakes plus the node-facing control bus.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface node_ctrl_if #(
  parameter int CNT_W  = node_ctrl_pkg::CNT_W,
  parameter int DATA_W = node_ctrl_pkg::DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic [CNT_W-1:0]  req_len;
  logic [CNT_W-1:0]  node_cnt_val;
  logic              node_start;
  logic              node_reset_acc;
  logic [DATA_W-1:0] node_out;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              busy;

  // master: scheduler plus node side; slave: the controller itself
  modport master (
    output req_valid, req_len, node_out, res_ready,
    input  req_ready, node_cnt_val, node_start, node_reset_acc,
           res_valid, res_data, busy
  );

  modport slave (
    input  req_valid, req_len, node_out, res_ready,
    output req_ready, node_cnt_val, node_start, node_reset_acc,
           res_valid, res_data, busy
  );

endinterface

`default_nettype wire

// File: rtl/node_ctrl.sv
//------------------------------------------------------------------------------
// node_ctrl : sequences one node MAC evaluation (clear, accumulate, drain,
// capture). Optional macro NODE_CTRL_RELU_EN applies ReLU to the result.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module node_ctrl
  import node_ctrl_pkg::*;
#(
  parameter int NUM_INPUTS = node_ctrl_pkg::NUM_INPUTS,
  parameter int CNT_W      = node_ctrl_pkg::CNT_W,
  parameter int DATA_W     = node_ctrl_pkg::DATA_W,
  parameter int PIPE_LAT   = 2
) (
  input  wire        clk,
  input  wire        rst,
  node_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(NUM_INPUTS);
  localparam logic [2:0]       LAT_LAST = 3'(PIPE_LAT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  len_q, len_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        lat, lat_nxt;
  logic [DATA_W-1:0] res_q, res_nxt;
  logic [CNT_W-1:0]  len_clamped;
  logic [DATA_W-1:0] captured;

  assign len_clamped = (bus.req_len > MAX_LEN) ? MAX_LEN : bus.req_len;

`ifdef NODE_CTRL_RELU_EN
  assign captured = bus.node_out[DATA_W-1] ? '0 : bus.node_out;
`else
  assign captured = bus.node_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      cnt   <= '0;
      lat   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      len_q <= len_nxt;
      cnt   <= cnt_nxt;
      lat   <= lat_nxt;
      res_q <= res_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    cnt_nxt   = cnt;
    lat_nxt   = lat;
    res_nxt   = res_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          len_nxt = len_clamped;
          if (len_clamped == '0) begin
            res_nxt   = '0;
            state_nxt = RESULT;
          end else begin
            state_nxt = CLEAR;
          end
        end
      end
      CLEAR: begin
        cnt_nxt   = '0;
        state_nxt = ACCUM;
      end
      ACCUM: begin
        // cnt stops at len_q-1 so it doubles as the held index during DRAIN
        if (cnt == len_q - CNT_W'(1)) begin
          lat_nxt   = '0;
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (lat == LAT_LAST) begin
          res_nxt   = captured;
          state_nxt = RESULT;
        end else begin
          lat_nxt = lat + 3'd1;
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready      = (state == IDLE);
  assign bus.busy           = (state != IDLE);
  assign bus.node_reset_acc = (state == CLEAR);
  assign bus.node_start     = (state == ACCUM);
  assign bus.node_cnt_val   = cnt;
  assign bus.res_valid      = (state == RESULT);
  assign bus.res_data       = res_q;

endmodule

`default_nettype wire

// File: tb/tb_node_ctrl.sv
//------------------------------------------------------------------------------
// tb_node_ctrl : randomized bench for node_ctrl with a behavioural node model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_node_ctrl;
  import node_ctrl_pkg::*;

  localparam int P = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  node_ctrl_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();

  node_ctrl #(
    .NUM_INPUTS(NUM_INPUTS),
    .CNT_W     (CNT_W),
    .DATA_W    (DATA_W),
    .PIPE_LAT  (P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Node model: accumulate wts[cnt_val] while start, visible P cycles after the term
  logic [DATA_W-1:0] wts [NUM_INPUTS];
  logic [DATA_W-1:0] acc, acc_d;
  logic              ovr_en;
  logic [DATA_W-1:0] ovr_val;

  always @(posedge clk) begin
    if (bus.node_reset_acc)  acc <= '0;
    else if (bus.node_start) acc <= acc + wts[bus.node_cnt_val];
    acc_d <= acc;
  end

  assign bus.node_out = ovr_en ? ovr_val : acc_d;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [DATA_W-1:0] expect_result(input int len);
    int L;
    logic [DATA_W-1:0] s;
    L = (len > NUM_INPUTS) ? NUM_INPUTS : len;
    s = '0;
    if (L == 0) return '0;
    for (int i = 0; i < L; i++) s = s + wts[i];
    if (ovr_en) s = ovr_val;
`ifdef NODE_CTRL_RELU_EN
    if (s[DATA_W-1]) s = '0;
`endif
    return s;
  endfunction

  task automatic randomize_wts();
    for (int i = 0; i < NUM_INPUTS; i++) wts[i] = DATA_W'($urandom_range(0, 1023));
  endtask

  // Flags vector: {busy, req_ready, reset_acc, start, res_valid}
  task automatic run_eval(input int len, input int hold, input bit pend_next);
    int L, k_res;
    logic [DATA_W-1:0] exp_d;
    logic [4:0] exp_f, got_f;
    bit saved_en;
    logic [DATA_W-1:0] saved_val;
    L     = (len > NUM_INPUTS) ? NUM_INPUTS : len;
    exp_d = expect_result(len);
    k_res = (L == 0) ? 1 : 2 + L + P;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_req_ready len=%0d got=%b want=1", len, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_len   = len[CNT_W-1:0];
    bus.res_ready = 1'b0;
    for (int k = 1; k <= k_res; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      exp_f = {1'b1, 1'b0, (L > 0 && k == 1), (L > 0 && k >= 2 && k < 2 + L), (k == k_res)};
      got_f = {bus.busy, bus.req_ready, bus.node_reset_acc, bus.node_start, bus.res_valid};
      n_checks++;
      if (got_f !== exp_f) begin
        n_fail++;
        $display("FAIL flags len=%0d cycle=%0d got=%b want=%b", len, k, got_f, exp_f);
      end
      if (L > 0 && k >= 2 && k < k_res) begin
        n_checks++;
        if (bus.node_cnt_val !== CNT_W'((k < 2 + L) ? k - 2 : L - 1)) begin
          n_fail++;
          $display("FAIL cnt_val len=%0d cycle=%0d got=%0d want=%0d", len, k,
                   bus.node_cnt_val, (k < 2 + L) ? k - 2 : L - 1);
        end
      end
    end
    n_checks++;
    if (bus.res_data !== exp_d) begin
      n_fail++;
      $display("FAIL res_data len=%0d got=%h want=%h", len, bus.res_data, exp_d);
    end
    if (pend_next) begin
      bus.req_valid = 1'b1;
      bus.req_len   = CNT_W'(3);
    end
    saved_en  = ovr_en;
    saved_val = ovr_val;
    for (int h = 0; h < hold; h++) begin
      ovr_en  = 1'b1;
      ovr_val = DATA_W'($urandom);
      @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.res_data !== exp_d) begin
        n_fail++;
        $display("FAIL hold len=%0d h=%0d valid=%b ready=%b data=%h want_data=%h",
                 len, h, bus.res_valid, bus.req_ready, bus.res_data, exp_d);
      end
    end
    ovr_en        = saved_en;
    ovr_val       = saved_val;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release len=%0d valid=%b ready=%b busy=%b want 0/1/0",
               len, bus.res_valid, bus.req_ready, bus.busy);
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [4:0] got_f;
    got_f = {bus.busy, bus.req_ready, bus.node_reset_acc, bus.node_start, bus.res_valid};
    n_checks++;
    if (got_f !== 5'b01000 || bus.res_data !== '0 || bus.node_cnt_val !== '0) begin
      n_fail++;
      $display("FAIL %s flags=%b data=%h cnt=%0d want flags=01000 data=0 cnt=0",
               tag, got_f, bus.res_data, bus.node_cnt_val);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
  endtask

  task automatic test_basic();
    randomize_wts();
    wts[0] = 16'h0010;
    wts[1] = 16'h0020;
    wts[2] = 16'h0030;
    wts[3] = 16'h0044;
    n_checks++;
    if (expect_result(4) !== 16'h00A4) begin
      n_fail++;
      $display("FAIL model_sum got=%h want=00a4", expect_result(4));
    end
    run_eval(4, 0, 1'b0);
  endtask

  task automatic test_zero_len();
    run_eval(0, 2, 1'b0);
  endtask

  task automatic test_clamp();
    randomize_wts();
    run_eval(100, 0, 1'b0);
    run_eval(64, 0, 1'b0);
    run_eval(65, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    randomize_wts();
    run_eval(5, 10, 1'b1);
    // pending request is taken on the IDLE cycle just checked
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.node_reset_acc !== 1'b1 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_accept clr=%b busy=%b ready=%b want 1/1/0",
               bus.node_reset_acc, bus.busy, bus.req_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("b2b_cleanup");
  endtask

  task automatic test_mid_reset();
    randomize_wts();
    bus.req_valid = 1'b1;
    bus.req_len   = CNT_W'(10);
    repeat (4) @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.node_start !== 1'b1 || bus.node_cnt_val !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL mid_accum start=%b cnt=%0d want 1/2", bus.node_start, bus.node_cnt_val);
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    ovr_en  = 1'b1;
    ovr_val = 16'hFF00;
    run_eval(3, 0, 1'b0);
    ovr_en  = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      randomize_wts();
      run_eval($urandom_range(0, 100), $urandom_range(0, 3), 1'b0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_len   = '0;
    bus.res_ready = 1'b0;
    ovr_en        = 1'b0;
    ovr_val       = '0;
    randomize_wts();
    test_reset();
    test_basic();
    test_zero_len();
    test_clamp();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
